iq_pair_sequencer: RTL and testbench



---
 rtl/iq_pair_sequencer_pkg.sv | 23 ++
 rtl/iq_pair_sequencer_if.sv | 32 +++
 rtl/iq_pair_sequencer_capture.sv | 47 ++++
 rtl/iq_pair_sequencer.sv | 118 +++++++++++
 tb/tb_iq_pair_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_pair_sequencer_pkg.sv
// Shared types and default geometry for the iq_demod sample path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iq_demod_pkg;

  localparam int IQ_SAMPLE_W  = 5;
  localparam int IQ_N_SAMPLES = 10;
  localparam int IQ_SEL_W     = 3;

  typedef logic [IQ_SAMPLE_W-1:0] iq_sample_t;
  typedef logic [IQ_SEL_W-1:0]    iq_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    SWEEP = 1'b1
  } iq_seq_state_t;

  // True when a select of sel_w bits can address every pair of the window.
  function automatic bit iq_sel_fits(input int sel_w, input int n_samples);
    return (1 << sel_w) >= (n_samples / 2);
  endfunction

endpackage

// File: rtl/iq_pair_sequencer_if.sv
// Sample input and pair-mux output bundle of the pair sequencer.
// Latency: n/a (wires only).
// Backpressure: pair_ready stalls the pair sweep; the sample side has none.
interface iq_pair_sequencer_if
  import iq_demod_pkg::*;
#(
  parameter int SAMPLE_W  = IQ_SAMPLE_W,
  parameter int N_SAMPLES = IQ_N_SAMPLES,
  parameter int SEL_W     = IQ_SEL_W
);

  logic [SAMPLE_W-1:0]           sample_in;
  logic                          sample_valid;
  logic [N_SAMPLES*SAMPLE_W-1:0] win_out;
  logic [SEL_W-1:0]              sel;
  logic                          pair_valid;
  logic                          pair_ready;
  logic                          last_pair;

  // Sequencer side: consumes samples, presents pairs.
  modport master (
    input  sample_in, sample_valid, pair_ready,
    output win_out, sel, pair_valid, last_pair
  );

  // Front end + correlator side.
  modport slave (
    output sample_in, sample_valid, pair_ready,
    input  win_out, sel, pair_valid, last_pair
  );

endinterface

// File: rtl/iq_pair_sequencer_capture.sv
// Capture bank: writes accepted samples into consecutive slots of one window.
// Latency: window_done pulses the cycle after the edge that accepts the last sample.
// Backpressure: none; every sample_valid beat is written.
module iq_sample_capture
  import iq_demod_pkg::*;
#(
  parameter int SAMPLE_W  = IQ_SAMPLE_W,
  parameter int N_SAMPLES = IQ_N_SAMPLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          window_done,
  output logic [N_SAMPLES*SAMPLE_W-1:0] cap_bank
);

  localparam int             CNT_W    = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  logic [CNT_W-1:0] cnt;

  // Slot write, slot counter wrap and one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      window_done <= 1'b0;
      cap_bank    <= '0;
    end else begin
      window_done <= 1'b0;
      if (sample_valid) begin
        for (int k = 0; k < N_SAMPLES; k++) begin
          if (cnt == CNT_W'(k)) begin
            cap_bank[k*SAMPLE_W +: SAMPLE_W] <= sample_in;
          end
        end
        if (cnt == CNT_LAST) begin
          cnt         <= '0;
          window_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iq_pair_sequencer.sv
// Window-to-pair sequencer feeding the iq_demod pair mux; optional IQ_PAIR_SEQ_OVF_CNT_EN adds ovf_count.
// Latency: window presented 1 cycle after the window_done pulse, 2 edges after the last sample.
// Backpressure: pair_ready holds sel/win_out; a window completing mid-sweep is dropped and flagged.
module iq_pair_sequencer
  import iq_demod_pkg::*;
#(
  parameter int SAMPLE_W  = IQ_SAMPLE_W,
  parameter int N_SAMPLES = IQ_N_SAMPLES,
  parameter int SEL_W     = IQ_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  iq_pair_sequencer_if.master  bus,
  output logic                 overflow
`ifdef IQ_PAIR_SEQ_OVF_CNT_EN
  ,
  output logic [7:0]           ovf_count
`endif
);

  localparam int               N_PAIRS  = N_SAMPLES / 2;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_PAIRS - 1);

  if (N_SAMPLES % 2 != 0) begin : g_odd_window
    $error("iq_pair_sequencer: N_SAMPLES must be even");
  end
  if (!iq_sel_fits(SEL_W, N_SAMPLES)) begin : g_sel_narrow
    $error("iq_pair_sequencer: SEL_W too small for N_SAMPLES/2 pairs");
  end

  iq_seq_state_t                 state;
  logic [N_SAMPLES*SAMPLE_W-1:0] win_q;
  logic [SEL_W-1:0]              sel_q;
  logic                          pv_q;
  logic                          window_done;
  logic [N_SAMPLES*SAMPLE_W-1:0] cap_bank;
  logic                          hs;
  logic                          final_hs;
  logic                          drop;

  iq_sample_capture #(
    .SAMPLE_W  (SAMPLE_W),
    .N_SAMPLES (N_SAMPLES)
  ) u_capture (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (bus.sample_in),
    .sample_valid (bus.sample_valid),
    .window_done  (window_done),
    .cap_bank     (cap_bank)
  );

  assign hs       = pv_q && bus.pair_ready;
  assign final_hs = hs && (sel_q == SEL_LAST);
  // A finished window only has somewhere to go when the output bank is idle or freeing up now.
  assign drop     = window_done && (state == SWEEP) && !final_hs;

  assign bus.win_out    = win_q;
  assign bus.sel        = sel_q;
  assign bus.pair_valid = pv_q;
  assign bus.last_pair  = pv_q && (sel_q == SEL_LAST);

  // Output-bank FSM: load on completion, step sel per handshake, reload back-to-back without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      win_q    <= '0;
      sel_q    <= '0;
      pv_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        EMPTY: begin
          if (window_done) begin
            win_q <= cap_bank;
            sel_q <= '0;
            pv_q  <= 1'b1;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (final_hs) begin
            sel_q <= '0;
            if (window_done) begin
              win_q <= cap_bank;
              pv_q  <= 1'b1;
            end else begin
              pv_q  <= 1'b0;
              state <= EMPTY;
            end
          end else if (hs) begin
            sel_q <= sel_q + 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          pv_q  <= 1'b0;
          sel_q <= '0;
        end
      endcase
    end
  end

`ifdef IQ_PAIR_SEQ_OVF_CNT_EN
  // Saturating count of dropped windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iq_pair_sequencer.sv
// Scoreboard bench for iq_pair_sequencer: expected pairs queued at stimulus, checked per handshake.
// Latency: drives on posedge+1, samples on negedge.
// Backpressure: pair_ready driven per test to exercise stalls, overflow and back-to-back reloads.
module tb_iq_pair_sequencer;
  import iq_demod_pkg::*;

  localparam int SW = IQ_SAMPLE_W;
  localparam int NS = IQ_N_SAMPLES;
  localparam int NP = NS / 2;
  localparam int WW = SW * NS;

  typedef struct packed {
    logic [WW-1:0]       win;
    logic [IQ_SEL_W-1:0] sel;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic overflow;
`ifdef IQ_PAIR_SEQ_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  always #5 clk = ~clk;

  iq_pair_sequencer_if bus ();

  iq_pair_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .overflow (overflow)
`ifdef IQ_PAIR_SEQ_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];

  logic [SW-1:0] s_a [NS];
  logic [SW-1:0] s_b [NS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack_win(input logic [SW-1:0] s [NS]);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < NS; k++) w[k*SW +: SW] = s[k];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one window; when it should be presented, queue its NP beats.
  task automatic send_window(input logic [SW-1:0] s [NS], input int gap, input bit present);
    beat_t b;
    for (int i = 0; i < NS; i++) begin
      bus.sample_in    = s[i];
      bus.sample_valid = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
      if (i < NS - 1) repeat (gap) tick();
    end
    if (present) begin
      b.win = pack_win(s);
      for (int p = 0; p < NP; p++) begin
        b.sel = IQ_SEL_W'(p);
        exp_q.push_back(b);
      end
    end
  endtask

  // Called right after the final sample's edge: window must appear exactly one edge later.
  task automatic check_load(input string tag, input logic [SW-1:0] s [NS]);
    chk({tag, "_early_pv"}, 64'(bus.pair_valid), 64'd0);
    tick();
    chk({tag, "_pv"}, 64'(bus.pair_valid), 64'd1);
    chk({tag, "_sel"}, 64'(bus.sel), 64'd0);
    chk({tag, "_win"}, 64'(bus.win_out), 64'(pack_win(s)));
  endtask

  task automatic wait_pv(input string tag);
    int n = 0;
    while (!bus.pair_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.pair_valid), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Handshake monitor: scoreboard pop plus hold/range checks.
  logic                prev_pv = 1'b0;
  logic                prev_hs = 1'b0;
  logic [IQ_SEL_W-1:0] prev_sel = '0;
  logic [WW-1:0]       prev_win = '0;
  beat_t               mb;

  always @(negedge clk) begin
    if (rst) begin
      prev_pv <= 1'b0;
      prev_hs <= 1'b0;
    end else begin
      if (prev_pv && !prev_hs) begin
        chk("pv_hold", 64'(bus.pair_valid), 64'd1);
        chk("sel_hold", 64'(bus.sel), 64'(prev_sel));
        chk("win_hold", 64'(bus.win_out), 64'(prev_win));
      end
      if (bus.pair_valid) begin
        chk("sel_range", 64'(bus.sel < IQ_SEL_W'(NP)), 64'd1);
      end else begin
        chk("last_idle", 64'(bus.last_pair), 64'd0);
      end
      if (bus.pair_valid && bus.pair_ready) begin
        chk("beat_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mb = exp_q.pop_front();
          chk("beat_win", 64'(bus.win_out), 64'(mb.win));
          chk("beat_sel", 64'(bus.sel), 64'(mb.sel));
          chk("beat_last", 64'(bus.last_pair), 64'(mb.sel == IQ_SEL_W'(NP - 1)));
        end
      end
      prev_pv  <= bus.pair_valid;
      prev_hs  <= bus.pair_valid && bus.pair_ready;
      prev_sel <= bus.sel;
      prev_win <= bus.win_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    bit pat [8];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst              = 1'b1;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.pair_ready   = 1'b0;
    repeat (2) tick();
    chk("rst_win", 64'(bus.win_out), 64'd0);
    chk("rst_sel", 64'(bus.sel), 64'd0);
    chk("rst_pv", 64'(bus.pair_valid), 64'd0);
    chk("rst_last", 64'(bus.last_pair), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    // 1: samples 1..10, free-running consumer.
    for (int i = 0; i < NS; i++) s_a[i] = SW'(i + 1);
    bus.pair_ready = 1'b1;
    send_window(s_a, 0, 1'b1);
    check_load("t1", s_a);
    wait_drain("t1_drain");
    chk("t1_idle", 64'(bus.pair_valid), 64'd0);

    // 2: stalled consumer with a ready pattern containing exactly NP ones.
    bus.pair_ready = 1'b0;
    for (int i = 0; i < NS; i++) s_a[i] = SW'(i * 3 + 2);
    send_window(s_a, 0, 1'b1);
    wait_pv("t2_pv");
    for (int i = 0; i < 8; i++) begin
      bus.pair_ready = pat[i];
      tick();
    end
    bus.pair_ready = 1'b0;
    chk("t2_drain", 64'(exp_q.size()), 64'd0);
    chk("t2_idle", 64'(bus.pair_valid), 64'd0);

    // 3: gapped input, alternating extremes.
    bus.pair_ready = 1'b1;
    for (int i = 0; i < NS; i++) s_a[i] = (i % 2 == 0) ? SW'(31) : SW'(0);
    send_window(s_a, 2, 1'b1);
    wait_drain("t3_drain");
    chk("t3_idle", 64'(bus.pair_valid), 64'd0);

    // 4a: back-to-back windows, consumer keeps up.
    for (int i = 0; i < NS; i++) s_a[i] = SW'(31 - i);
    for (int i = 0; i < NS; i++) s_b[i] = SW'((i * 7) % 32);
    send_window(s_a, 0, 1'b1);
    send_window(s_b, 0, 1'b1);
    check_load("t4a", s_b);
    wait_drain("t4a_drain");
    chk("t4a_ovf", 64'(overflow), 64'd0);

    // 4b: second window completes on the final handshake of the first.
    bus.pair_ready = 1'b0;
    for (int i = 0; i < NS; i++) s_a[i] = SW'(i + 11);
    for (int i = 0; i < NS; i++) s_b[i] = SW'((i * 5 + 3) % 32);
    fork
      begin
        send_window(s_a, 0, 1'b1);
        send_window(s_b, 0, 1'b1);
      end
      begin
        wait_pv("t4b_pv");
        repeat (5) tick();
        bus.pair_ready = 1'b1;
        repeat (5) tick();
        chk("t4b_nobubble_pv", 64'(bus.pair_valid), 64'd1);
        chk("t4b_nobubble_sel", 64'(bus.sel), 64'd0);
        chk("t4b_nobubble_win", 64'(bus.win_out), 64'(pack_win(s_b)));
      end
    join
    wait_drain("t4b_drain");
    chk("t4b_ovf", 64'(overflow), 64'd0);

    // 5: consumer stalled while a whole second window arrives.
    bus.pair_ready = 1'b0;
    for (int i = 0; i < NS; i++) s_a[i] = SW'(i + 16);
    for (int i = 0; i < NS; i++) s_b[i] = SW'(21);
    send_window(s_a, 0, 1'b1);
    send_window(s_b, 0, 1'b0);
    repeat (2) tick();
    chk("t5_ovf", 64'(overflow), 64'd1);
    chk("t5_pv", 64'(bus.pair_valid), 64'd1);
    chk("t5_sel", 64'(bus.sel), 64'd0);
    chk("t5_win", 64'(bus.win_out), 64'(pack_win(s_a)));
`ifdef IQ_PAIR_SEQ_OVF_CNT_EN
    chk("t5_ovf_count", 64'(ovf_count), 64'd1);
`endif
    bus.pair_ready = 1'b1;
    wait_drain("t5_drain");
    chk("t5_idle", 64'(bus.pair_valid), 64'd0);

    // 6: reset mid-sweep with a partial window captured.
    bus.pair_ready = 1'b0;
    for (int i = 0; i < NS; i++) s_a[i] = SW'(i * 2);
    send_window(s_a, 0, 1'b1);
    wait_pv("t6_pv");
    bus.pair_ready = 1'b1;
    repeat (2) tick();
    bus.pair_ready = 1'b0;
    chk("t6_sel2", 64'(bus.sel), 64'd2);
    for (int i = 0; i < 4; i++) begin
      bus.sample_in    = SW'(31);
      bus.sample_valid = 1'b1;
      tick();
    end
    bus.sample_valid = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("t6_rst_win", 64'(bus.win_out), 64'd0);
    chk("t6_rst_sel", 64'(bus.sel), 64'd0);
    chk("t6_rst_pv", 64'(bus.pair_valid), 64'd0);
    chk("t6_rst_ovf", 64'(overflow), 64'd0);
`ifdef IQ_PAIR_SEQ_OVF_CNT_EN
    chk("t6_rst_ovf_count", 64'(ovf_count), 64'd0);
`endif
    rst = 1'b0;
    bus.pair_ready = 1'b1;
    for (int i = 0; i < NS; i++) s_a[i] = SW'(30 - i);
    send_window(s_a, 0, 1'b1);
    check_load("t6", s_a);
    wait_drain("t6_drain");
    chk("t6_idle", 64'(bus.pair_valid), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
